cam_frame_sched: RTL

//  Sequences one-shot frame grabs between UART command link, MT9V034 pixel port and frame RAM.
//  A capture byte from uart_receive arms the block. It skips any frame already in progress, writes the next full frame
//  (pixel bits [9:2]) into RAM, then streams the RAM contents out to the UART transmitter.

---
 rtl/cam_frame_sched_pkg.sv | 52 +++++
 rtl/cam_frame_sched_if.sv | 32 +++
 rtl/cam_frame_sched_tx_seq.sv | 94 +++++++++
 rtl/cam_frame_sched.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cam_frame_sched_pkg.sv
// Shared types and constants for the camera frame scheduler.
// Optional macro CAM_FRAME_HDR_EN adds the sync/frame-count header and 0xFF escaping.
package cam_frame_sched_pkg;

  localparam int unsigned FRAME_W_DEF = 2;
  localparam int unsigned FRAME_H_DEF = 3;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned CNT_W       = ADDR_W + 1;
  localparam int unsigned PIX_W       = 10;

  localparam logic [7:0] CAPTURE_CMD_DEF = 8'hAA;
  localparam logic [7:0] SYNC_B0         = 8'hFF;
  localparam logic [7:0] SYNC_B1         = 8'h00;
  localparam logic [7:0] PIX_ESC         = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_FV,
    ST_CAPTURE,
    ST_SEND
`ifdef CAM_FRAME_HDR_EN
    ,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2
`endif
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ADDR,
    TX_DATA,
    TX_HOLD
  } tx_state_e;

  // Direct byte load into the transmit register (header bytes).
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } tx_load_t;

  // Pixel byte as it goes on the wire; 0xFF is reserved for sync when headers are on.
  function automatic logic [7:0] tx_pixel(input logic [7:0] b);
`ifdef CAM_FRAME_HDR_EN
    return (b == SYNC_B0) ? PIX_ESC : b;
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/cam_frame_sched_if.sv
// Command, camera, frame-RAM and transmitter signals of the frame scheduler.
interface cam_frame_sched_if;
  import cam_frame_sched_pkg::*;

  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic              cam_frame_valid;
  logic              cam_line_valid;
  logic [PIX_W-1:0]  cam_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              err_short;

  modport slave (
    input  cmd_data, cmd_ready, cam_frame_valid, cam_line_valid, cam_data,
           mem_rdata, tx_ready,
    output mem_we, mem_addr, mem_wdata, tx_data, tx_valid, busy, err_short
  );

  modport master (
    output cmd_data, cmd_ready, cam_frame_valid, cam_line_valid, cam_data,
           mem_rdata, tx_ready,
    input  mem_we, mem_addr, mem_wdata, tx_data, tx_valid, busy, err_short
  );

endinterface

// File: rtl/cam_frame_sched_tx_seq.sv
// Send-side sequencer: reads len bytes from frame RAM and hands them to the transmitter,
// one byte in flight; also accepts directly loaded bytes while idle.
module cam_frame_sched_tx_seq
  import cam_frame_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  tx_load_t          load,
  input  logic [7:0]        rdata,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              xfer;

  assign xfer     = valid_q & tx_ready;
  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign addr     = addr_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Address is held through TX_ADDR; RAM data is valid and latched in TX_DATA.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (xfer) valid_d = 1'b0;
        if (load.valid) begin
          data_d  = load.data;
          valid_d = 1'b1;
        end
        if (start) begin
          addr_d  = '0;
          len_d   = len;
          state_d = TX_ADDR;
        end
      end
      TX_ADDR: state_d = TX_DATA;
      TX_DATA: begin
        data_d  = tx_pixel(rdata);
        valid_d = 1'b1;
        state_d = TX_HOLD;
      end
      TX_HOLD: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (CNT_W'(addr_q) + CNT_W'(1) >= len_q) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = TX_ADDR;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/cam_frame_sched.sv
// One-shot frame grab: command decode, capture FSM and pixel count; streaming via tx_seq.
// Define CAM_FRAME_HDR_EN for FF/00/frame-count header and 0xFF->0xFE pixel escaping.
module cam_frame_sched
  import cam_frame_sched_pkg::*;
#(
  parameter int unsigned FRAME_W     = FRAME_W_DEF,
  parameter int unsigned FRAME_H     = FRAME_H_DEF,
  parameter logic [7:0]  CAPTURE_CMD = CAPTURE_CMD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  cam_frame_sched_if.slave bus
);

  localparam int unsigned      FRAME_PIX   = FRAME_W * FRAME_H;
  localparam logic [CNT_W-1:0] FRAME_PIX_N = CNT_W'(FRAME_PIX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic              seq_start;
  logic              seq_done;
  tx_load_t          seq_load;
  logic [ADDR_W-1:0] seq_addr;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [7:0]        wdata_c;
  logic [1:0]        unused_pix_lsb;
`ifdef CAM_FRAME_HDR_EN
  logic [7:0]        fcnt_q, fcnt_d;
  logic              xfer;

  assign xfer = bus.tx_valid & bus.tx_ready;
`endif

  assign unused_pix_lsb = bus.cam_data[1:0];
  assign bus.mem_we     = we_c;
  assign bus.mem_addr   = addr_c;
  assign bus.mem_wdata  = wdata_c;
  assign bus.busy       = busy_q;
  assign bus.err_short  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CAM_FRAME_HDR_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
`ifdef CAM_FRAME_HDR_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  // RAM write strobe is combinational with the pixel sample so no pipeline is needed.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    err_d     = err_q;
    seq_start = 1'b0;
    seq_load  = '0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
`ifdef CAM_FRAME_HDR_EN
    fcnt_d    = fcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_ready && (bus.cmd_data == CAPTURE_CMD)) begin
          state_d = ST_ARM;
          err_d   = 1'b0;
          n_d     = '0;
        end
      end
      ST_ARM: if (!bus.cam_frame_valid) state_d = ST_WAIT_FV;
      ST_WAIT_FV: if (bus.cam_frame_valid) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (bus.cam_frame_valid) begin
          if (bus.cam_line_valid && (n_q < FRAME_PIX_N)) begin
            we_c    = 1'b1;
            addr_c  = n_q[ADDR_W-1:0];
            wdata_c = bus.cam_data[PIX_W-1:PIX_W-8];
            n_d     = n_q + CNT_W'(1);
          end
        end else begin
          if (n_q < FRAME_PIX_N) err_d = 1'b1;
          if (n_q == '0) begin
            state_d = ST_IDLE;
          end else begin
`ifdef CAM_FRAME_HDR_EN
            state_d  = ST_HDR0;
            seq_load = '{valid: 1'b1, data: SYNC_B0};
`else
            state_d   = ST_SEND;
            seq_start = 1'b1;
`endif
          end
        end
      end
`ifdef CAM_FRAME_HDR_EN
      // Each header byte is loaded on the transfer of the previous one.
      ST_HDR0: begin
        if (xfer) begin
          state_d  = ST_HDR1;
          seq_load = '{valid: 1'b1, data: SYNC_B1};
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          state_d  = ST_HDR2;
          seq_load = '{valid: 1'b1, data: fcnt_q};
          fcnt_d   = fcnt_q + 8'd1;
        end
      end
      ST_HDR2: begin
        if (xfer) begin
          state_d   = ST_SEND;
          seq_start = 1'b1;
        end
      end
`endif
      ST_SEND: begin
        addr_c = seq_addr;
        if (seq_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cam_frame_sched_tx_seq u_tx_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (seq_start),
    .len      (n_q),
    .load     (seq_load),
    .rdata    (bus.mem_rdata),
    .tx_ready (bus.tx_ready),
    .tx_valid (bus.tx_valid),
    .tx_data  (bus.tx_data),
    .addr     (seq_addr),
    .done     (seq_done)
  );

endmodule
